loop_channel_emulator: RTL and testbench

- Synthesisable multi-channel loopback emulator for board bring-up and self-test of the measurement control path.
- Takes the DAC sample stream and produces N_CH emulated ADC channels.
- Each channel has its own run-time programmable sample delay (phase shift), arithmetic attenuation and optional inversion.
- Sits between the DAC output register and the ADC input mux, selected in test mode.

---
 rtl/loop_channel_emulator.sv | 140 ++++++++++++++
 tb/tb_loop_channel_emulator.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/loop_channel_emulator.sv
// Multi-channel DAC-to-ADC loopback emulator: shared circular sample buffer with
// per-channel programmable delay, arithmetic attenuation and saturating inversion.
module loop_channel_emulator #(
    parameter int unsigned W         = 14,
    parameter int unsigned N_CH      = 2,
    parameter int unsigned MAX_DELAY = 64,
    parameter int unsigned CH_W      = 3
) (
    input  logic                         clk125,
    input  logic                         areset_n,
    input  logic                         en,
    input  logic signed [W-1:0]          dac_in,
    input  logic                         cfg_wr,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic [$clog2(MAX_DELAY)-1:0] cfg_delay,
    input  logic [$clog2(W)-1:0]         cfg_shift,
    input  logic                         cfg_neg,
    output logic                         cfg_err,
    output logic [N_CH*W-1:0]            adc_out,
    output logic [N_CH-1:0]              adc_valid
);

    localparam int unsigned DW = $clog2(MAX_DELAY);
    localparam int unsigned SW = $clog2(W);
    localparam logic [CH_W:0] NumCh = (CH_W + 1)'(N_CH);
    localparam logic signed [W-1:0] SMin = {1'b1, {(W - 1){1'b0}}};
    localparam logic signed [W-1:0] SMax = {1'b0, {(W - 1){1'b1}}};

    typedef enum logic {StFlush, StRun} ch_state_e;

    logic [W-1:0]  mem [MAX_DELAY];
    logic [DW-1:0] wp_q;
    logic          cfg_err_q;

    // Buffer RAM is intentionally not reset; FLUSH keeps stale contents from reaching outputs.
    always_ff @(posedge clk125) begin
        if (en) begin
            mem[wp_q] <= dac_in;
        end
    end

    always_ff @(posedge clk125 or negedge areset_n) begin
        if (!areset_n) begin
            wp_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (en) begin
                wp_q <= wp_q + 1'b1;
            end
            cfg_err_q <= cfg_wr && ({1'b0, cfg_ch} >= NumCh);
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        ch_state_e            state_q, state_d;
        logic [DW-1:0]        delay_q, delay_d;
        logic [DW-1:0]        fill_q, fill_d;
        logic [SW-1:0]        shift_q, shift_d;
        logic                 neg_q, neg_d;
        logic                 valid_q, valid_d;
        logic signed [W-1:0]  out_q, out_d;
        logic signed [W-1:0]  tap, shifted, res;
        logic [DW-1:0]        addr;
        logic                 sel;

        assign sel  = cfg_wr && (cfg_ch == CH_W'(c));
        // Asynchronous read of the slot about to be overwritten gives the oldest sample at D=MAX-1.
        assign addr = wp_q - delay_q;
        assign tap  = (delay_q == '0) ? dac_in : mem[addr];

        always_comb begin
            shifted = tap >>> shift_q;
            res     = shifted;
            if (neg_q) begin
                res = (shifted == SMin) ? SMax : -shifted;
            end
        end

        always_comb begin
            state_d = state_q;
            delay_d = delay_q;
            fill_d  = fill_q;
            shift_d = shift_q;
            neg_d   = neg_q;
            valid_d = valid_q;
            out_d   = out_q;
            if (sel) begin
                delay_d = cfg_delay;
                shift_d = cfg_shift;
                neg_d   = cfg_neg;
                state_d = StFlush;
                fill_d  = '0;
                valid_d = 1'b0;
                out_d   = '0;
            end else if (en) begin
                unique case (state_q)
                    StFlush: begin
                        if (fill_q == delay_q) begin
                            out_d   = res;
                            valid_d = 1'b1;
                            state_d = StRun;
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end
                    StRun: begin
                        out_d = res;
                    end
                    default: state_d = StFlush;
                endcase
            end
        end

        always_ff @(posedge clk125 or negedge areset_n) begin
            if (!areset_n) begin
                state_q <= StFlush;
                delay_q <= '0;
                fill_q  <= '0;
                shift_q <= '0;
                neg_q   <= 1'b0;
                valid_q <= 1'b0;
                out_q   <= '0;
            end else begin
                state_q <= state_d;
                delay_q <= delay_d;
                fill_q  <= fill_d;
                shift_q <= shift_d;
                neg_q   <= neg_d;
                valid_q <= valid_d;
                out_q   <= out_d;
            end
        end

        assign adc_out[c*W +: W] = out_q;
        assign adc_valid[c]      = valid_q;
    end

endmodule

// File: tb/tb_loop_channel_emulator.sv
// Randomized self-checking bench for loop_channel_emulator against a sample-history model.
module tb_loop_channel_emulator;

    localparam int W = 14;
    localparam int N_CH = 2;
    localparam int MAX_DELAY = 64;
    localparam int CH_W = 3;

    logic                  clk125 = 1'b0;
    logic                  areset_n = 1'b0;
    logic                  en = 1'b0;
    logic signed [W-1:0]   dac_in = '0;
    logic                  cfg_wr = 1'b0;
    logic [CH_W-1:0]       cfg_ch = '0;
    logic [5:0]            cfg_delay = '0;
    logic [3:0]            cfg_shift = '0;
    logic                  cfg_neg = 1'b0;
    logic                  cfg_err;
    logic [N_CH*W-1:0]     adc_out;
    logic [N_CH-1:0]       adc_valid;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: history of accepted samples plus per-channel count of strobes since configuration.
    int m_d[N_CH], m_s[N_CH], m_cnt[N_CH], m_out[N_CH];
    bit m_neg[N_CH], m_val[N_CH];
    bit m_err;
    int hist[$];

    loop_channel_emulator #(
        .W(W), .N_CH(N_CH), .MAX_DELAY(MAX_DELAY), .CH_W(CH_W)
    ) dut (
        .clk125    (clk125),
        .areset_n  (areset_n),
        .en        (en),
        .dac_in    (dac_in),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .cfg_shift (cfg_shift),
        .cfg_neg   (cfg_neg),
        .cfg_err   (cfg_err),
        .adc_out   (adc_out),
        .adc_valid (adc_valid)
    );

    always #4 clk125 = ~clk125;

    function automatic int atten(int x, int s, bit n);
        int p;
        int y;
        p = 1 << s;
        if (x >= 0) y = x / p;
        else        y = -((-x + p - 1) / p);
        if (n) begin
            y = -y;
            if (y > 8191) y = 8191;
        end
        return y;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_d[c] = 0; m_s[c] = 0; m_neg[c] = 0;
            m_cnt[c] = 0; m_out[c] = 0; m_val[c] = 0;
        end
        m_err = 0;
        hist.delete();
    endtask

    task automatic model_update();
        int x;
        x = int'(dac_in);
        m_err = cfg_wr && (int'(cfg_ch) >= N_CH);
        if (en) begin
            hist.push_back(x);
            if (hist.size() > MAX_DELAY) void'(hist.pop_front());
        end
        for (int c = 0; c < N_CH; c++) begin
            if (cfg_wr && int'(cfg_ch) == c) begin
                m_d[c] = int'(cfg_delay); m_s[c] = int'(cfg_shift); m_neg[c] = cfg_neg;
                m_cnt[c] = 0; m_val[c] = 0; m_out[c] = 0;
            end else if (en) begin
                m_cnt[c]++;
                if (m_cnt[c] > m_d[c]) begin
                    m_out[c] = atten(hist[hist.size() - 1 - m_d[c]], m_s[c], m_neg[c]);
                    m_val[c] = 1;
                end
            end
        end
    endtask

    task automatic check(string tag, int obs, int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < N_CH; c++) begin
            logic signed [W-1:0] o;
            o = adc_out[c*W +: W];
            check($sformatf("adc_valid[%0d]", c), int'(adc_valid[c]), int'(m_val[c]));
            check($sformatf("adc_out[%0d]", c), int'(o), m_out[c]);
        end
        check("cfg_err", int'(cfg_err), int'(m_err));
    endtask

    task automatic tick();
        @(posedge clk125);
        model_update();
        #1;
        check_all();
    endtask

    task automatic drive(bit e, int x);
        en = e;
        dac_in = W'(x);
        tick();
    endtask

    task automatic cfg(int ch, int d, int s, bit n, bit e, int x);
        cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_delay = 6'(d);
        cfg_shift = 4'(s); cfg_neg = n;
        drive(e, x);
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_reset();
        areset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        areset_n = 1'b1;
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(16383)) - 8192;
    endfunction

    initial begin
        model_reset();
        #3;
        check_all();
        repeat (2) @(posedge clk125);
        #1;
        areset_n = 1'b1;

        // D=0 bypass with a ramp
        for (int i = 0; i < 40; i++) drive(1, i);

        // Long delays on both channels with random full-scale input
        cfg(0, 20, 0, 0, 1, rnd_sample());
        cfg(1, 30, 1, 0, 1, rnd_sample());
        for (int i = 0; i < 100; i++) drive(1, (i == 50) ? -8191 : rnd_sample());

        // Maximum delay across several pointer wraps
        cfg(0, 63, 0, 0, 0, 0);
        for (int i = 0; i < 220; i++) drive(1, i - 100);

        // Inversion saturation
        cfg(1, 0, 0, 1, 0, 0);
        drive(1, -8192); drive(1, 8191); drive(1, 0);
        for (int i = 0; i < 20; i++) drive(1, rnd_sample());

        // Gapped strobes with D=4
        cfg(0, 4, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(i % 2 == 0, rnd_sample());
        for (int i = 0; i < 30; i++) drive($urandom_range(1), rnd_sample());

        // Reconfigure ch1 mid-stream, invalid channel, simultaneous and back-to-back writes
        cfg(1, 3, 2, 1, 1, rnd_sample());
        for (int i = 0; i < 6; i++) drive(1, rnd_sample());
        cfg(5, 10, 3, 1, 1, rnd_sample());
        drive(1, rnd_sample());
        cfg(1, 7, 0, 0, 1, rnd_sample());
        cfg(1, 2, 1, 0, 1, rnd_sample());
        for (int i = 0; i < 10; i++) drive(1, rnd_sample());
        pulse_reset();
        for (int i = 0; i < 10; i++) drive(1, rnd_sample());

        // Random mix of configuration, gaps and resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) begin
                cfg($urandom_range(3), ($urandom_range(3) == 0) ? $urandom_range(63)
                                                                 : $urandom_range(8),
                    $urandom_range(15), $urandom_range(1), $urandom_range(1), rnd_sample());
            end else if ($urandom_range(499) == 0) begin
                pulse_reset();
            end else begin
                drive($urandom_range(3) != 0, rnd_sample());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
